// File: rtl/mips_exec_pkg.sv
// Shared ALU control and funct codes for the MIPS execute stage.
// Optional NOR operation is enabled with the ALU_NOR_EN macro.
package mips_exec_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_NOR = 3'b100;

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0010;
  localparam logic [3:0] FN_AND = 4'b0100;
  localparam logic [3:0] FN_OR  = 4'b0101;
  localparam logic [3:0] FN_SLT = 4'b1010;
  localparam logic [3:0] FN_NOR = 4'b0111;

endpackage

// File: rtl/mips_exec_if.sv
// Execute-stage bus: control/operand inputs and registered EX/MEM outputs.
// master drives the operation, slave is the execute unit.
interface mips_exec_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             alu_op1;
  logic             alu_op0;
  logic [3:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] branch_off;

  logic             out_valid;
  logic [2:0]       alu_ctl;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [WIDTH-1:0] pc_plus_4;
  logic [WIDTH-1:0] branch_target;

  modport master (
    output in_valid, alu_op1, alu_op0, funct,
    output a, b, pc, branch_off,
    input  out_valid, alu_ctl, result, zero,
    input  pc_plus_4, branch_target
  );

  modport slave (
    input  in_valid, alu_op1, alu_op0, funct,
    input  a, b, pc, branch_off,
    output out_valid, alu_ctl, result, zero,
    output pc_plus_4, branch_target
  );

endinterface

// File: rtl/mips_exec_alu_decode.sv
// ALU-control decoder: ALUOp plus funct to a 3-bit ALU operation.
// ALU_NOR_EN adds the NOR decode for funct 0111.
module mips_exec_alu_decode
  import mips_exec_pkg::*;
(
  input  logic       alu_op1,
  input  logic       alu_op0,
  input  logic [3:0] funct,
  output logic [2:0] alu_ctl
);

  logic [2:0] fn_ctl;

  // R-type funct field to ALU operation
  always_comb begin
    fn_ctl = ALU_ADD;
    unique case (funct)
      FN_ADD: fn_ctl = ALU_ADD;
      FN_SUB: fn_ctl = ALU_SUB;
      FN_AND: fn_ctl = ALU_AND;
      FN_OR:  fn_ctl = ALU_OR;
      FN_SLT: fn_ctl = ALU_SLT;
`ifdef ALU_NOR_EN
      FN_NOR: fn_ctl = ALU_NOR;
`else
      FN_NOR: fn_ctl = ALU_ADD;
`endif
      default: fn_ctl = ALU_ADD;
    endcase
  end

  // branch compare wins, then load/store add, then R-type
  always_comb begin
    alu_ctl = ALU_ADD;
    unique case (1'b1)
      alu_op0:             alu_ctl = ALU_SUB;
      !alu_op0 && !alu_op1: alu_ctl = ALU_ADD;
      !alu_op0 && alu_op1:  alu_ctl = fn_ctl;
      default:             alu_ctl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_exec_unit.sv
// MIPS execute stage: ALU control, ALU, PC+4 and branch-target adders.
// Outputs registered once (EX/MEM); ALU_NOR_EN enables the NOR operation.
module mips_exec_unit
  import mips_exec_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int PC_INC = 4
) (
  input  logic clk,
  input  logic rst_n,
  mips_exec_if.slave bus
);

  logic [2:0]       ctl;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] p4;
  logic [WIDTH-1:0] bt;

  mips_exec_alu_decode u_dec (
    .alu_op1 (bus.alu_op1),
    .alu_op0 (bus.alu_op0),
    .funct   (bus.funct),
    .alu_ctl (ctl)
  );

  // ALU datapath; unknown codes produce zero
  always_comb begin
    res = '0;
    case (ctl)
      ALU_AND: res = bus.a & bus.b;
      ALU_OR:  res = bus.a | bus.b;
      ALU_ADD: res = bus.a + bus.b;
      ALU_SUB: res = bus.a - bus.b;
      ALU_SLT: res = {{(WIDTH-1){1'b0}},
                      $signed(bus.a) < $signed(bus.b)};
`ifdef ALU_NOR_EN
      ALU_NOR: res = ~(bus.a | bus.b);
`else
      ALU_NOR: res = '0;
`endif
      default: res = '0;
    endcase
  end

  // sequential and branch addresses; wrap silently
  always_comb begin
    p4 = bus.pc + WIDTH'(PC_INC);
    bt = p4 + bus.branch_off;
  end

  // EX/MEM register, captured every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid     <= 1'b0;
      bus.alu_ctl       <= '0;
      bus.result        <= '0;
      bus.zero          <= 1'b0;
      bus.pc_plus_4     <= '0;
      bus.branch_target <= '0;
    end else begin
      bus.out_valid     <= bus.in_valid;
      bus.alu_ctl       <= ctl;
      bus.result        <= res;
      bus.zero          <= (res == '0);
      bus.pc_plus_4     <= p4;
      bus.branch_target <= bt;
    end
  end

endmodule

// File: tb/tb_mips_exec_unit.sv
// Bench for mips_exec_unit: directed cases plus random ops
// against a behavioural model.
module tb_mips_exec_unit;

  localparam int W = 32;

  typedef enum {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_NOR} op_e;

  typedef struct {
    logic        v;
    logic [2:0]  ctl;
    logic [31:0] res;
    logic        z;
    logic [31:0] p4;
    logic [31:0] bt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int total = 0;
  int bad = 0;

  mips_exec_if #(.WIDTH(W)) bus ();

  mips_exec_unit #(.WIDTH(W), .PC_INC(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic op_e pick_op(input logic op1, input logic op0,
                                  input logic [3:0] fn);
    if (op0) return OP_SUB;
    if (!op1) return OP_ADD;
    if (fn == 4'd0) return OP_ADD;
    if (fn == 4'd2) return OP_SUB;
    if (fn == 4'd4) return OP_AND;
    if (fn == 4'd5) return OP_OR;
    if (fn == 4'd10) return OP_SLT;
`ifdef ALU_NOR_EN
    if (fn == 4'd7) return OP_NOR;
`endif
    return OP_ADD;
  endfunction

  function automatic exp_t model(input logic v, input logic op1,
                                 input logic op0, input logic [3:0] fn,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] pc,
                                 input logic [31:0] off);
    exp_t e;
    longint sa;
    longint sb;
    op_e op;
    op = pick_op(op1, op0, fn);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.v = v;
    case (op)
      OP_ADD: begin e.ctl = 3'b010; e.res = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000); end
      OP_SUB: begin e.ctl = 3'b110; e.res = 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000); end
      OP_AND: begin e.ctl = 3'b000; e.res = a & b; end
      OP_OR:  begin e.ctl = 3'b001; e.res = a | b; end
      OP_SLT: begin e.ctl = 3'b111; e.res = (sa < sb) ? 32'd1 : 32'd0; end
      default: begin e.ctl = 3'b100; e.res = ~(a | b); end
    endcase
    e.z  = (e.res == 32'd0);
    e.p4 = 32'((64'(pc) + 64'd4) % 64'h1_0000_0000);
    e.bt = 32'((64'(pc) + 64'd4 + 64'(off)) % 64'h1_0000_0000);
    return e;
  endfunction

  exp_t cur;

  task automatic drive(input logic v, input logic op1, input logic op0,
                       input logic [3:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc,
                       input logic [31:0] off);
    bus.in_valid   = v;
    bus.alu_op1    = op1;
    bus.alu_op0    = op0;
    bus.funct      = fn;
    bus.a          = a;
    bus.b          = b;
    bus.pc         = pc;
    bus.branch_off = off;
    cur = model(v, op1, op0, fn, a, b, pc, off);
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(e.v));
    chk({tag, ".ctl"}, 32'(bus.alu_ctl), 32'(e.ctl));
    chk({tag, ".result"}, bus.result, e.res);
    chk({tag, ".zero"}, 32'(bus.zero), 32'(e.z));
    chk({tag, ".pc4"}, bus.pc_plus_4, e.p4);
    chk({tag, ".bt"}, bus.branch_target, e.bt);
  endtask

  task automatic check_zero(input string tag);
    exp_t e;
    e = '{1'b0, 3'd0, 32'd0, 1'b0, 32'd0, 32'd0};
    check_out(tag, e);
  endtask

  task automatic step(input string tag);
    exp_t e;
    e = cur;
    @(posedge clk);
    #1;
    check_out(tag, e);
  endtask

  initial begin
    logic [31:0] corner [4];
    logic [3:0]  fns [7];
    logic [31:0] ra;
    logic [31:0] rb;
    corner = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000};
    fns = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd10, 4'd7, 4'd15};

    drive(1, 0, 0, 4'd0, 32'h10, 32'h8, 32'h0, 32'h0);
    #1 rst_n = 1'b0;
    #2 check_zero("reset_async");
    @(posedge clk);
    #1 check_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;

    step("ldst_addr");

    drive(1, 0, 1, 4'd0, 32'h5, 32'h5, 32'h8, 32'h10);
    step("beq_eq");

    drive(1, 1, 0, 4'd0, 32'hC, 32'hA, 32'h100, 32'h4);
    step("r_add");
    drive(1, 1, 0, 4'd2, 32'hC, 32'hA, 32'h104, 32'h4);
    step("r_sub");
    drive(1, 1, 0, 4'd4, 32'hC, 32'hA, 32'h108, 32'h4);
    step("r_and");
    drive(1, 1, 0, 4'd5, 32'hC, 32'hA, 32'h10C, 32'h4);
    step("r_or");
    drive(1, 1, 0, 4'd10, 32'hC, 32'hA, 32'h110, 32'h4);
    step("r_slt");
    drive(1, 1, 0, 4'd10, 32'hFFFF_FFFF, 32'h1, 32'h114, 32'h4);
    step("r_slt_neg");

    drive(1, 1, 0, 4'd0, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFC, 32'h8);
    step("wrap");
    drive(1, 1, 0, 4'd15, 32'h3, 32'h4, 32'h20, 32'hFFFF_FFF0);
    step("fn_default");
    drive(0, 1, 0, 4'd7, 32'h0F0F_0000, 32'h0000_0F0F, 32'h40, 32'h0);
    step("nor_opt");

    drive(1, 1, 0, 4'd2, 32'h77, 32'h11, 32'h200, 32'h20);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 4'd0, 32'h30, 32'h4, 32'h300, 32'h8);
    step("after_reset");

    for (int i = 0; i < 300; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)]
                                       : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)]
                                       : $urandom;
      if ($urandom_range(0, 7) == 0) rb = ra;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0) ? 4'($urandom)
                                        : fns[$urandom_range(0, 6)],
            ra, rb, $urandom, $urandom);
      step($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_exec_unit.md
Name: mips_exec_unit

Overview:
- Execute-stage block of the single-cycle MIPS datapath: the ALU-control decoder, the 32-bit ALU, the PC+4 adder and the branch-target adder in one unit.
- Inputs come from the control unit, the register-file read ports, the sign-extend/shift path and the PC.
- Outputs are registered once, so the block acts as an EX/MEM boundary with a valid flag.

Parameters:
- WIDTH, 32, datapath width of operands, PC and results.
- PC_INC, 4, constant added to pc for the sequential-next address.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  inputs are valid this cycle.
- alu_op1  in  1  ALUOp bit 1 from control (R-type).
- alu_op0  in  1  ALUOp bit 0 from control (branch compare).
- funct  in  4  instruction bits [3:0].
- a  in  WIDTH  operand A (register read data 1).
- b  in  WIDTH  operand B (output of the ALU-source mux).
- pc  in  WIDTH  current program counter.
- branch_off  in  WIDTH  sign-extended immediate, already shifted left by 2.
- out_valid  out  1  registered in_valid.
- alu_ctl  out  3  registered decoded ALU operation.
- result  out  WIDTH  registered ALU result.
- zero  out  1  registered flag, high when the ALU result equals 0.
- pc_plus_4  out  WIDTH  registered pc + PC_INC.
- branch_target  out  WIDTH  registered pc + PC_INC + branch_off.

Behaviour:
- ALU-control decode is combinational, with priority in this order:
  - alu_op0=1 gives SUB (110), regardless of alu_op1 and funct.
  - Otherwise alu_op1=0 gives ADD (010).
  - Otherwise funct selects the operation: 0000 gives ADD 010; 0010 gives SUB 110; 0100 gives AND 000; 0101 gives OR 001; 1010 gives SLT 111.
  - Any other funct gives ADD 010.
- ALU is combinational:
  - AND gives a&b; OR gives a|b.
  - ADD gives a+b modulo 2^WIDTH; carry-out is discarded.
  - SUB gives a-b modulo 2^WIDTH.
  - SLT gives 1 when a<b as signed two's-complement, else 0, zero-extended.
  - Any other code gives 0.
- zero is 1 exactly when the combinational result is all zeros.
- Both adders are plain unsigned WIDTH-bit adds; wrap-around is silent (for example pc=32'hFFFFFFFC gives pc_plus_4=0).
- branch_target uses the already-shifted offset. This block performs no shifting.
- Register stage: on every rising clk, all outputs load their combinational values, whether in_valid is high or low. out_valid <= in_valid.
- Latency is exactly 1 cycle. There is no stall or backpressure; a new operation can be accepted every cycle.
- Reset: while rst_n=0, all outputs are held at 0, including out_valid and zero, asynchronously. The first capture happens on the first rising clk after rst_n deasserts.
- Reset asserted mid-operation: the in-flight result is discarded and the outputs clear immediately.
- The branch-taken decision (branch && zero) and PC muxing are external to this block.

Optional Feature:
- Macro: ALU_NOR_EN.
- With ALU_NOR_EN defined:
  - funct 0111 with alu_op1=1 and alu_op0=0 decodes to NOR (100).
  - The ALU computes ~(a|b) for code 100.
- Without ALU_NOR_EN: funct 0111 falls to the default ADD (010), and code 100 yields result 0.

Decomposition:
- Shared package mips_exec_pkg holds:
  - The localparams for the ALU control codes: ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_SLT=3'b111, ALU_NOR=3'b100.
  - The funct codes: FN_ADD=4'b0000, FN_SUB=4'b0010, FN_AND=4'b0100, FN_OR=4'b0101, FN_SLT=4'b1010, FN_NOR=4'b0111.
- One sub-module is natural: mips_exec_alu_decode, a combinational map from alu_op1, alu_op0 and funct to alu_ctl. The ALU and the adders stay inline in the top.

Test Plan:
- Reset: assert rst_n=0 mid-stream with in_valid=1 -> all outputs 0 immediately; after release, the first captured op appears one cycle later.
- Load/store address: alu_op=00, a=32'h10, b=32'h8, pc=32'h0, branch_off=32'h0 -> next cycle: alu_ctl=010, result=32'h18, zero=0, pc_plus_4=32'h4.
- Branch compare: alu_op0=1, a=b=32'h5, pc=32'h8, branch_off=32'h10 -> result=0, zero=1, pc_plus_4=32'hC, branch_target=32'h1C.
- R-type sweep, a=32'h0000000C, b=32'h0000000A:
  - add -> 32'h16; sub -> 32'h2; and -> 32'h8; or -> 32'hE.
  - slt -> 0.
  - slt with a=32'hFFFFFFFF, b=1 -> 1 (signed compare).
- Wrap and default: a=32'hFFFFFFFF, b=1 with add -> result=0, zero=1. pc=32'hFFFFFFFC -> pc_plus_4=0. funct=1111 with alu_op=10 -> alu_ctl=010.
- ALU_NOR_EN: funct=0111, alu_op=10, a=32'h0F0F0000, b=32'h00000F0F:
  - With the macro defined -> alu_ctl=100, result=32'hF0F0F0F0.
  - Without the macro -> alu_ctl=010, result=32'h0F0F0F0F.
